// File: rtl/uart_fifo.sv
// uart_fifo: register-mapped UART with TX/RX FIFOs, programmable divisor, parity, stop bits and interrupt
module uart_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16,
   parameter int DIV_RESET  = 433
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic        re,
   input  logic [2:0]  reg_num,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   input  logic        rx,
   output logic        tx,
   output logic        irq
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
   logic [6:0] ctrl;
   logic [DIV_W-1:0] div, dv;
   logic [3:0] sticky, sticky_set, sticky_clr;
   logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
   logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
   logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
   logic [AW:0] tx_lvl, rx_lvl;
   logic tx_empty, tx_full, rx_empty, rx_full;
   logic tx_req, tx_push, tx_pop, rx_req, rx_push, rx_pop;
   state_t ts, ts_n, rs, rs_n;
   logic [DIV_W-1:0] t_div, t_ck, r_div, r_ck;
   logic [DIV_W:0] half;
   logic [3:0] t_bit, r_bit;
   logic [DATA_BITS-1:0] t_sh, r_sh;
   logic t_pen, t_par, t_two, t_stop2, t_tick;
   logic r_pen, r_odd, r_tick, r_mid;
   logic rs1, rs2, rs3, r_fall, perr_set, ferr_set;
   assign dv = div < DIV_W'(3) ? DIV_W'(3) : div;
   assign tx_empty = tx_lvl == '0;
   assign rx_empty = rx_lvl == '0;
   assign tx_full = tx_lvl == (AW+1)'(FIFO_DEPTH);
   assign rx_full = rx_lvl == (AW+1)'(FIFO_DEPTH);
   assign tx_req = we && reg_num == 3'd0;
   assign tx_pop = ts == IDLE && ctrl[0] && !tx_empty;
   assign tx_push = tx_req && (!tx_full || tx_pop);
   assign rx_pop = re && reg_num == 3'd0 && !rx_empty;
   assign rx_push = rx_req && (!rx_full || rx_pop);
   assign t_tick = t_ck == t_div;
   assign half = ({1'b0, r_div} + 1'b1) >> 1;
   assign r_mid = r_ck == half[DIV_W-1:0] - 1'b1;
   assign r_tick = r_ck == r_div;
   assign r_fall = rs3 && !rs2;
   assign rx_req = rs == STOP && r_tick && rs2;
   assign ferr_set = rs == STOP && r_tick && !rs2;
   assign perr_set = rs == PARITY && r_tick && (^r_sh ^ rs2 ^ r_odd);
   assign sticky_set = {tx_req && !tx_push, rx_req && !rx_push, ferr_set, perr_set};
   assign sticky_clr = (we && reg_num == 3'd1) ? wd[9:6] : 4'd0;
   assign tx = ts == START ? 1'b0 : ts == DATA ? t_sh[0] : ts == PARITY ? t_par : 1'b1;
   assign rd = reg_num == 3'd0 ? 32'(rx_mem[rx_rp]) :
               reg_num == 3'd1 ? {22'd0, sticky, rs != IDLE, ts != IDLE, rx_full, rx_empty, tx_full, tx_empty} :
               reg_num == 3'd2 ? {25'd0, ctrl} :
               reg_num == 3'd3 ? 32'(div) :
               reg_num == 3'd4 ? {16'(rx_lvl), 16'(tx_lvl)} : 32'd0;
   always_comb begin
      ts_n = ts;
      case (ts)
         IDLE:    ts_n = tx_pop ? START : IDLE;
         START:   ts_n = t_tick ? DATA : START;
         DATA:    ts_n = (t_tick && t_bit == 4'(DATA_BITS-1)) ? (t_pen ? PARITY : STOP) : DATA;
         PARITY:  ts_n = t_tick ? STOP : PARITY;
         STOP:    ts_n = (t_tick && (!t_two || t_stop2)) ? IDLE : STOP;
         default: ts_n = IDLE;
      endcase
   end
   always_comb begin
      rs_n = rs;
      case (rs)
         IDLE:    rs_n = (ctrl[1] && r_fall) ? START : IDLE;
         START:   rs_n = r_mid ? (rs2 ? IDLE : DATA) : START;
         DATA:    rs_n = (r_tick && r_bit == 4'(DATA_BITS-1)) ? (r_pen ? PARITY : STOP) : DATA;
         PARITY:  rs_n = r_tick ? STOP : PARITY;
         STOP:    rs_n = r_tick ? (rs2 ? IDLE : BREAK) : STOP;
         BREAK:   rs_n = rs2 ? IDLE : BREAK;
         default: rs_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp] <= wd[DATA_BITS-1:0];
      if (rx_push) rx_mem[rx_wp] <= r_sh;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         ts <= IDLE;
         rs <= IDLE;
         t_ck <= '0;
         r_ck <= '0;
         {rs1, rs2, rs3} <= 3'b111;
         tx_wp <= '0;
         tx_rp <= '0;
         rx_wp <= '0;
         rx_rp <= '0;
         tx_lvl <= '0;
         rx_lvl <= '0;
         ctrl <= '0;
         div <= DIV_W'(DIV_RESET);
         sticky <= '0;
         irq <= 1'b0;
      end else begin
         ts <= ts_n;
         rs <= rs_n;
         {rs3, rs2, rs1} <= {rs2, rs1, rx};
         t_ck <= (ts == IDLE || t_tick) ? '0 : t_ck + 1'b1;
         r_ck <= (rs == IDLE || r_tick || (rs == START && r_mid)) ? '0 : r_ck + 1'b1;
         if (tx_pop) begin
            t_sh <= tx_mem[tx_rp];
            t_par <= ^tx_mem[tx_rp] ^ ctrl[3];
            t_div <= dv;
            t_pen <= ^ctrl[3:2];
            t_two <= ctrl[4];
            t_stop2 <= 1'b0;
            t_bit <= '0;
         end
         if (ts == DATA && t_tick) begin
            t_sh <= t_sh >> 1;
            t_bit <= t_bit + 1'b1;
         end
         if (ts == STOP && t_tick) t_stop2 <= 1'b1;
         if (rs == IDLE) begin
            r_div <= dv;
            r_pen <= ^ctrl[3:2];
            r_odd <= ctrl[3];
            r_bit <= '0;
         end
         if (rs == DATA && r_tick) begin
            r_sh <= {rs2, r_sh[DATA_BITS-1:1]};
            r_bit <= r_bit + 1'b1;
         end
         if (tx_push) tx_wp <= tx_wp + 1'b1;
         if (tx_pop) tx_rp <= tx_rp + 1'b1;
         if (rx_push) rx_wp <= rx_wp + 1'b1;
         if (rx_pop) rx_rp <= rx_rp + 1'b1;
         tx_lvl <= tx_lvl + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
         rx_lvl <= rx_lvl + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
         if (we && reg_num == 3'd2) ctrl <= wd[6:0];
         if (we && reg_num == 3'd3) div <= wd[DIV_W-1:0];
         sticky <= (sticky & ~sticky_clr) | sticky_set;
         irq <= (ctrl[5] && !rx_empty) || (ctrl[6] && tx_empty) || (ctrl[5] && |sticky[2:0]);
      end
   end
endmodule
